// File: rtl/my_register.sv
// my_register: WIDTH-bit parallel-load register that updates on a slow tick from its own clock divider.
// Define MY_REGISTER_SYNC_EN to pass load/d through a 2-flop synchronizer before use.
module my_register #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int TICK_HZ  = 1,
   parameter int WIDTH    = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             clk_1Hz
);

   localparam int HALF  = (TICK_HZ > 0) ? (CLK_FREQ / (2 * TICK_HZ)) : 0;
   localparam int CNT_W = (HALF > 1) ? $clog2(HALF + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);

   generate
      if (HALF < 1) begin : g_bad_half
         $error("my_register: CLK_FREQ/(2*TICK_HZ) must be >= 1");
      end
   endgenerate

   logic [CNT_W-1:0] cnt_r;
   logic             clk_1hz_r;
   logic [WIDTH-1:0] q_r;
   logic             load_s;
   logic [WIDTH-1:0] d_s;
   logic             wrap_s;
   logic             tick_s;

`ifdef MY_REGISTER_SYNC_EN
   logic             load_meta_r;
   logic             load_sync_r;
   logic [WIDTH-1:0] d_meta_r;
   logic [WIDTH-1:0] d_sync_r;

   // Two-stage synchronizer for the switch inputs.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         load_meta_r <= 1'b0;
         load_sync_r <= 1'b0;
         d_meta_r    <= {WIDTH{1'b0}};
         d_sync_r    <= {WIDTH{1'b0}};
      end else begin
         load_meta_r <= load;
         load_sync_r <= load_meta_r;
         d_meta_r    <= d;
         d_sync_r    <= d_meta_r;
      end
   end

   assign load_s = load_sync_r;
   assign d_s    = d_sync_r;
`else
   assign load_s = load;
   assign d_s    = d;
`endif

   // Wrap and tick decode; the tick is the edge on which clk_1Hz rises.
   always_comb begin
      wrap_s = (cnt_r == CNT_LAST);
      tick_s = wrap_s && !clk_1hz_r;
   end

   // Divider counter and square-wave output.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         cnt_r     <= {CNT_W{1'b0}};
         clk_1hz_r <= 1'b0;
      end else if (wrap_s) begin
         cnt_r     <= {CNT_W{1'b0}};
         clk_1hz_r <= ~clk_1hz_r;
      end else begin
         cnt_r     <= cnt_r + CNT_W'(1'b1);
         clk_1hz_r <= clk_1hz_r;
      end
   end

   // Data register, loaded only on a tick with load asserted.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         q_r <= {WIDTH{1'b0}};
      end else if (tick_s && load_s) begin
         q_r <= d_s;
      end else begin
         q_r <= q_r;
      end
   end

   assign q       = q_r;
   assign clk_1Hz = clk_1hz_r;

endmodule

// File: tb/tb_my_register.sv
// Self-checking bench for my_register: table-driven tick vectors, hand-written corner sequences,
// and randomized stimulus against an edge-counting reference model (HALF=4 and HALF=1 instances).
module tb_my_register;

   localparam int HALF  = 4;
`ifdef MY_REGISTER_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic       clk = 1'b0;
   logic       clr;
   logic       load;
   logic [3:0] d;
   logic [3:0] q;
   logic       clk_1Hz;
   logic [3:0] q1;
   logic       clk1_1Hz;

   int errors = 0;
   int checks = 0;

   always #2 clk = ~clk;

   my_register #(.CLK_FREQ(8), .TICK_HZ(1), .WIDTH(4)) u_dut (
      .clk(clk), .clr(clr), .load(load), .d(d), .q(q), .clk_1Hz(clk_1Hz)
   );

   my_register #(.CLK_FREQ(2), .TICK_HZ(1), .WIDTH(4)) u_dut1 (
      .clk(clk), .clr(clr), .load(load), .d(d), .q(q1), .clk_1Hz(clk1_1Hz)
   );

   typedef struct packed {
      logic       ld;
      logic [3:0] dv;
   } samp_t;

   typedef struct {
      logic       ld;
      logic [3:0] dv;
      logic [3:0] exp_q;
   } vec_t;

   // Reference model: edges since reset release, input history, expected outputs.
   int         n;
   samp_t      hist[$];
   logic [3:0] mq;
   logic [3:0] mq1;
   vec_t       tbl[8];

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      n   = 0;
      mq  = 4'h0;
      mq1 = 4'h0;
      hist.delete();
   endtask

   // Apply inputs at the falling edge, advance one rising edge, compare at the next falling edge.
   task automatic cycle(input logic ld, input logic [3:0] dv);
      samp_t s;
      load = ld;
      d    = dv;
      @(posedge clk);
      n++;
      hist.push_back({ld, dv});
      if (hist.size() > 8) void'(hist.pop_front());
      if (hist.size() > LAT) s = hist[hist.size() - 1 - LAT];
      else s = '0;
      if ((n % (2 * HALF)) == HALF && s.ld) mq = s.dv;
      if ((n % 2) == 1 && s.ld) mq1 = s.dv;
      @(negedge clk);
      chk("model_q", q, mq);
      chk("model_clk", {3'b000, clk_1Hz}, {3'b000, 1'(((n / HALF) % 2) == 1)});
      chk("model_q_h1", q1, mq1);
      chk("model_clk_h1", {3'b000, clk1_1Hz}, {3'b000, 1'((n % 2) == 1)});
   endtask

   initial begin
      tbl[0] = '{1'b1, 4'hF, 4'hF};
      tbl[1] = '{1'b0, 4'h5, 4'hF};
      tbl[2] = '{1'b0, 4'h5, 4'hF};
      tbl[3] = '{1'b0, 4'h5, 4'hF};
      tbl[4] = '{1'b1, 4'hA, 4'hA};
      tbl[5] = '{1'b0, 4'h3, 4'hA};
      tbl[6] = '{1'b1, 4'h0, 4'h0};
      tbl[7] = '{1'b1, 4'hC, 4'hC};

      clr  = 1'b0;
      load = 1'b1;
      d    = 4'hF;
      model_reset();

      // Reset hold for 100 ns with load/d active.
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         chk("rst_q", q, 4'h0);
         chk("rst_clk", {3'b000, clk_1Hz}, 4'h0);
         chk("rst_q_h1", q1, 4'h0);
      end

      // Table of tick-level vectors: first tick HALF edges after release, then every 2*HALF.
      clr = 1'b1;
      model_reset();
      for (int i = 0; i < 8; i++) begin
         for (int c = 0; c < ((i == 0) ? HALF : 2 * HALF); c++) cycle(tbl[i].ld, tbl[i].dv);
         chk("tbl_q", q, tbl[i].exp_q);
         chk("tbl_clk", {3'b000, clk_1Hz}, 4'h1);
      end

      // Toggle load/d between ticks; q must stay 4'hC.
      for (int c = 1; c <= 2 * HALF; c++) begin
         cycle((c <= 2 * HALF - 3) ? 1'($urandom_range(0, 1)) : 1'b0, 4'($urandom));
         chk("between_q", q, 4'hC);
      end

      // Async reset at cnt=2 with clk_1Hz high.
      cycle(1'b0, 4'h0);
      cycle(1'b0, 4'h0);
      chk("pre_rst_clk", {3'b000, clk_1Hz}, 4'h1);
      clr = 1'b0;
      #1;
      chk("async_q", q, 4'h0);
      chk("async_clk", {3'b000, clk_1Hz}, 4'h0);
      chk("async_q_h1", q1, 4'h0);
      @(negedge clk);
      clr = 1'b1;
      model_reset();
      for (int c = 1; c <= HALF; c++) begin
         cycle(1'b1, 4'h5);
         chk("restart_clk", {3'b000, clk_1Hz}, (c == HALF) ? 4'h1 : 4'h0);
      end
      chk("restart_q", q, 4'h5);

      // d changed 1 clk before a tick (n=12).
      for (int c = 0; c < 7; c++) cycle(1'b1, 4'h6);
      cycle(1'b1, 4'h9);
`ifdef MY_REGISTER_SYNC_EN
      chk("late_d_q", q, 4'h6);
`else
      chk("late_d_q", q, 4'h9);
`endif

      // d changed 3 clks before a tick (n=20): captured in both builds.
      for (int c = 0; c < 5; c++) cycle(1'b1, 4'h3);
      for (int c = 0; c < 3; c++) cycle(1'b1, 4'h7);
      chk("early_d_q", q, 4'h7);

      // Randomized stimulus against the reference model.
      for (int i = 0; i < 300; i++) cycle(1'($urandom_range(0, 1)), 4'($urandom));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
